// File: rtl/series_pkg.sv
// rtl/series_pkg.sv - shared types, defaults and width helpers for the series loader
package series_pkg;

    localparam int N_DEF     = 32;
    localparam int WIDTH_DEF = 32;

    typedef logic [WIDTH_DEF-1:0] word_t;

    localparam word_t PAD_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // CNT_W must hold the value N itself; IDX_W only addresses slots 0..N-1.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/series_bank.sv
// rtl/series_bank.sv - one N-word batch buffer with state, count and count-masked parallel read
module series_bank
    import series_pkg::*;
#(
    parameter int N                  = N_DEF,
    parameter int WIDTH              = WIDTH_DEF,
    parameter logic [WIDTH-1:0] PAD_WORD = PAD_WORD_DEF,
    localparam int CNT_W             = cnt_w(N),
    localparam int IDX_W             = idx_w(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               close,
    input  logic               rel,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   count,
    output logic [N*WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [N];
    bank_state_e      state_q;

    // Storage is never cleared: the count mask hides anything stale.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A write and a release never target the same bank: a FULL bank blocks writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            count   <= '0;
        end else if (rel) begin
            state_q <= EMPTY;
            count   <= '0;
        end else if (we) begin
            if (close) begin
                state_q <= FULL;
                count   <= CNT_W'(wr_idx) + CNT_W'(1);
            end else begin
                state_q <= FILLING;
            end
        end
    end

    assign state = state_q;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N; k++) begin
            rd_data[k*WIDTH +: WIDTH] = (CNT_W'(k) < count) ? mem[k] : PAD_WORD;
        end
    end

endmodule

// File: rtl/series_loader.sv
// rtl/series_loader.sv - ping-pong word-to-batch packer feeding series_reducer
module series_loader
    import series_pkg::*;
#(
    parameter int N                  = N_DEF,
    parameter int WIDTH              = WIDTH_DEF,
    parameter logic [WIDTH-1:0] PAD_WORD = PAD_WORD_DEF,
    localparam int CNT_W             = cnt_w(N),
    localparam int IDX_W             = idx_w(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] numbers,
    output logic [CNT_W-1:0]   batch_count,
    output logic               batch_valid,
    input  logic               batch_ready
);

    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_idx;

    logic [1:0]         state0, state1;
    logic [CNT_W-1:0]   count0, count1;
    logic [N*WIDTH-1:0] rd0, rd1;

    logic accept, close, rel;
    logic [1:0] wr_state, rd_state;

    assign wr_state    = wr_bank ? state1 : state0;
    assign rd_state    = rd_bank ? state1 : state0;

    // Ready depends only on registered state and reset, never on in_valid.
    assign in_ready    = (wr_state != FULL) && !reset;
    assign accept      = in_valid && in_ready;
    assign close       = accept && ((wr_idx == IDX_W'(N - 1)) || in_last);

    assign batch_valid = (rd_state == FULL);
    assign rel         = batch_valid && batch_ready;
    assign numbers     = rd_bank ? rd1 : rd0;
    assign batch_count = batch_valid ? (rd_bank ? count1 : count0) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            if (accept) begin
                wr_idx <= close ? '0 : wr_idx + IDX_W'(1);
            end
            if (close) begin
                wr_bank <= ~wr_bank;
            end
            if (rel) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    series_bank #(.N(N), .WIDTH(WIDTH), .PAD_WORD(PAD_WORD)) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .we      (accept && !wr_bank),
        .close   (close && !wr_bank),
        .rel     (rel && !rd_bank),
        .wr_idx  (wr_idx),
        .wr_data (in_data),
        .state   (state0),
        .count   (count0),
        .rd_data (rd0)
    );

    series_bank #(.N(N), .WIDTH(WIDTH), .PAD_WORD(PAD_WORD)) u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .we      (accept && wr_bank),
        .close   (close && wr_bank),
        .rel     (rel && rd_bank),
        .wr_idx  (wr_idx),
        .wr_data (in_data),
        .state   (state1),
        .count   (count1),
        .rd_data (rd1)
    );

endmodule

// File: tb/tb_series_loader.sv
// tb/tb_series_loader.sv - table-driven self-checking bench for series_loader with N=4
module tb_series_loader;

    localparam int N     = 4;
    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [N*WIDTH-1:0] numbers;
    logic [2:0]         batch_count;
    logic               batch_valid;
    logic               batch_ready;

    series_loader #(.N(N), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .numbers     (numbers),
        .batch_count (batch_count),
        .batch_valid (batch_valid),
        .batch_ready (batch_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic         v;
        logic         l;
        logic [31:0]  d;
        logic         br;
        logic         ir;
        logic         bv;
        logic [2:0]   c;
        logic [127:0] n;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_miss    = 0;

    localparam logic [31:0] A = 32'h3F80_0000;
    localparam logic [31:0] B = 32'h4000_0000;
    localparam logic [31:0] C = 32'h4040_0000;
    localparam logic [31:0] D = 32'h4080_0000;

    function automatic logic [31:0] w(input int k);
        return 32'hA5A5_0000 + 32'(k);
    endfunction

    function automatic logic [127:0] pk(input logic [31:0] w3, w2, w1, w0);
        return {w3, w2, w1, w0};
    endfunction

    function automatic vec_t mk(input logic r, v, l, input logic [31:0] d, input logic br,
                                input logic ir, bv, input logic [2:0] c, input logic [127:0] n);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.d = d; t.br = br;
        t.ir = ir; t.bv = bv; t.c = c; t.n = n;
        return t;
    endfunction

    task automatic drive(input logic r, v, l, input logic [31:0] d, input logic br);
        reset = r; in_valid = v; in_last = l; in_data = d; batch_ready = br;
    endtask

    task automatic check(input string name, input logic ir, bv, input logic [2:0] c,
                         input logic [127:0] n);
        n_applied++;
        if (in_ready !== ir || batch_valid !== bv || batch_count !== c || numbers !== n) begin
            n_miss++;
            $display("FAIL %s: got ir=%b bv=%b cnt=%0d num=%h, want ir=%b bv=%b cnt=%0d num=%h",
                     name, in_ready, batch_valid, batch_count, numbers, ir, bv, c, n);
        end
    endtask

    initial begin
        logic [127:0] z;
        logic [127:0] p1;
        z = '0;
        p1 = pk(w(4), w(3), w(2), w(1));

        // reset held with in_valid high
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, A, 0, 0, 0, 0, z));
        // full batch, consumer always ready
        vecs.push_back(mk(0, 1, 0, A, 1, 1, 0, 0, z));
        vecs.push_back(mk(0, 1, 0, B, 1, 1, 0, 0, z));
        vecs.push_back(mk(0, 1, 0, C, 1, 1, 0, 0, z));
        vecs.push_back(mk(0, 1, 0, D, 1, 1, 0, 0, z));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4, pk(D, C, B, A)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, z));
        // short batch in bank1; next word goes to slot 0 of bank0
        vecs.push_back(mk(0, 1, 0, A, 0, 1, 0, 0, z));
        vecs.push_back(mk(0, 1, 1, B, 0, 1, 0, 0, z));
        vecs.push_back(mk(0, 1, 0, C, 0, 1, 1, 2, pk(0, 0, B, A)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, pk(0, 0, B, A)));
        vecs.push_back(mk(0, 0, 1, A, 0, 1, 0, 0, z));
        vecs.push_back(mk(0, 1, 1, D, 0, 1, 0, 0, z));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, pk(0, 0, D, C)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2, pk(0, 0, D, C)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, z));
        // backpressure: nine words, consumer stalled
        for (int k = 1; k <= 4; k++) vecs.push_back(mk(0, 1, 0, w(k), 0, 1, 0, 0, z));
        for (int k = 5; k <= 8; k++) vecs.push_back(mk(0, 1, 0, w(k), 0, 1, 1, 4, p1));
        vecs.push_back(mk(0, 1, 0, w(9), 0, 0, 1, 4, p1));
        vecs.push_back(mk(0, 1, 0, w(9), 1, 0, 1, 4, p1));
        vecs.push_back(mk(0, 1, 0, w(9), 0, 1, 1, 4, pk(w(8), w(7), w(6), w(5))));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, pk(w(8), w(7), w(6), w(5))));
        // fill bank1 to wr_idx=3, then close it in the same cycle bank0 is released
        vecs.push_back(mk(0, 1, 0, w(10), 0, 1, 1, 4, pk(w(8), w(7), w(6), w(5))));
        vecs.push_back(mk(0, 1, 0, w(11), 0, 1, 1, 4, pk(w(8), w(7), w(6), w(5))));
        vecs.push_back(mk(0, 1, 0, w(12), 1, 1, 1, 4, pk(w(8), w(7), w(6), w(5))));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 4, pk(w(12), w(11), w(10), w(9))));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 4, pk(w(12), w(11), w(10), w(9))));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, z));

        drive(1, 1, 0, A, 0);
        @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].br);
            #1;
            check($sformatf("vec%0d", i), vecs[i].ir, vecs[i].bv, vecs[i].c, vecs[i].n);
        end

        // reset mid-batch discards two accepted words
        @(negedge clk); drive(0, 1, 0, w(20), 0);
        @(negedge clk); drive(0, 1, 0, w(21), 0);
        @(negedge clk); drive(1, 0, 0, 0, 1);
        #1 check("mid_reset_hold", 0, 0, 0, z);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        #1 check("mid_reset_after", 1, 0, 0, z);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive(0, 1, 0, w(30 + k), 0);
        end
        @(negedge clk); drive(0, 0, 0, 0, 0);
        begin
            int waited = 0;
            while (!batch_valid && waited < 10) begin
                @(negedge clk); waited++;
            end
            #1;
        end
        check("mid_reset_clean", 1, 1, 4, pk(w(33), w(32), w(31), w(30)));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
